ber_checker_param: RTL and testbench
====================================

Name: ber_checker_param

Overview:
Parametrised bit-error-rate checker for the Procom TX/RX chain, one per slicer output channel. It compares the received slicer bit stream against the local PRBS reference. It sweeps DEPTH candidate reference delays, one error-counting window per delay, and locks on the best one. Once locked it accumulates bit and error counts. It optionally drops lock and re-searches when the error rate in a window exceeds a threshold.

Parameters:
DEPTH, 1024, number of candidate reference delays (history length); power of two, >= 4
WIN, 511, valid samples per search/monitor window
LOCK_THR, 0, max window errors at best position accepted as lock
LOSS_THR, 64, window errors above which lock is lost (used only with BER_RELOCK_EN)
CNT_W, 64, width of bit/error accumulators
PW, $clog2(DEPTH), position width (derived, localparam)
EW, $clog2(WIN+1), window error counter width (derived, localparam)

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous, active-low reset
i_enable  in  1  global enable; low freezes all state
i_valid  in  1  sample strobe for i_data/i_ref
i_data  in  1  received bit from slicer
i_ref  in  1  PRBS reference bit
i_clear  in  1  clears o_err_count/o_bit_count, lock unaffected
o_locked  out  1  optimum delay found, counting active
o_position  out  PW  selected delay index (valid when o_locked)
o_min_err  out  EW  error count of best window in last completed sweep
o_err_count  out  CNT_W  errors accumulated while locked
o_bit_count  out  CNT_W  bits accumulated while locked
o_resync_count  out  16  number of lock losses (saturating)

Behaviour:
- Reset (i_reset==0 at posedge): state=SEARCH; history, position, window counters, min tracker cleared. min_err=all ones. All outputs 0, except o_min_err=all ones. Reset mid-operation aborts any sweep or lock.
- Sample event s = i_enable & i_valid. No state changes when i_enable==0. Nothing advances on cycles with i_valid==0.
- History: ref_hist[DEPTH-1:0] shifts on s, with ref_hist[0] <= i_ref. Comparison err = i_data ^ ref_hist[pos] uses the pre-shift value, so position p means a delay of p+1 samples.
- SEARCH:
  - pos steps 0..DEPTH-1; win_err accumulates err over WIN sample events per pos.
  - At the last sample of a window, the error count includes that sample (win_err+err). If this total < best, best and best_pos are updated. The comparison is strict, so the lowest index wins ties.
  - win_err then clears and pos increments, wrapping from DEPTH-1 to 0.
  - End of sweep (window at pos DEPTH-1 done): o_min_err <= best.
    - If best <= LOCK_THR: go to LOCKED, o_position <= best_pos, o_locked <= 1 on the same edge.
    - Otherwise: best <= all ones and a new sweep starts at pos 0.
- LOCKED:
  - Each s increments o_bit_count, and increments o_err_count when err==1.
  - Both counters saturate at 2^CNT_W-1.
  - A monitor window (WIN samples) keeps running.
- i_clear: zeroes both accumulators. It wins over a simultaneous sample; that sample is not counted.
- Latency: o_locked rises on the edge that consumes the final sample of the sweep. Counting starts with the next sample event.

Optional Feature:
BER_RELOCK_EN.
- Defined: in LOCKED, when a monitor window completes with errors > LOSS_THR:
  - o_locked <= 0, o_resync_count increments (saturating at 16'hFFFF).
  - State returns to SEARCH at pos 0 with best cleared; accumulators hold their values.
  - A window ending with exactly LOSS_THR errors keeps lock.
- Undefined: LOCKED is terminal until reset. The monitor window logic is absent and o_resync_count is tied to 0.

Test Plan:
1. DEPTH=16, WIN=31, error-free i_data = i_ref delayed 5 samples -> after 496 valid samples: o_locked=1, o_position=4, o_min_err=0.
2. Same setup with one bit flipped in every window -> o_locked stays 0, o_min_err=1 after each sweep, sweeps repeat.
3. Locked; 1000 valid samples with 3 injected errors, i_valid toggling 50% -> o_bit_count=1000, o_err_count=3. Then i_clear together with valid -> both counters 0 and the concurrent sample is not counted.
4. i_enable low for 100 cycles mid-sweep -> all outputs and internal position unchanged; sweep resumes exactly where it stopped.
5. With BER_RELOCK_EN, LOSS_THR=4: after lock, switch the delay to 9 -> o_locked falls at the window end, o_resync_count=1, relock with o_position=8. Also check a window with exactly 4 errors keeps lock.
6. i_reset=0 asserted mid-LOCKED -> next edge: o_locked=0, counters=0, o_min_err=all ones; a fresh search locks again as in test 1.

Source files
------------

// File: rtl/ber_checker_param.sv
// Bit-error-rate checker: sweeps DEPTH reference delays, locks on the best one, then accumulates bit/error counts.
// Optional macro BER_RELOCK_EN: drop lock and re-search when a monitor window exceeds LOSS_THR errors.
module ber_checker_param #(
    parameter int DEPTH    = 1024,
    parameter int WIN      = 511,
    parameter int LOCK_THR = 0,
    parameter int LOSS_THR = 64,
    parameter int CNT_W    = 64,
    localparam int PW      = $clog2(DEPTH),
    localparam int EW      = $clog2(WIN + 1)
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_data,
    input  logic             i_ref,
    input  logic             i_clear,
    output logic             o_locked,
    output logic [PW-1:0]    o_position,
    output logic [EW-1:0]    o_min_err,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [15:0]      o_resync_count
);

    localparam logic [EW-1:0] WIN_LAST   = EW'(WIN - 1);
    localparam logic [EW-1:0] LOCK_THR_C = EW'(LOCK_THR);
    localparam logic [PW-1:0] POS_LAST   = PW'(DEPTH - 1);

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    state_t            state_q;
    logic [DEPTH-1:0]  hist_q;
    logic [PW-1:0]     pos_q;
    logic [PW-1:0]     position_q;
    logic [PW-1:0]     best_pos_q;
    logic [EW-1:0]     win_cnt_q;
    logic [EW-1:0]     win_err_q;
    logic [EW-1:0]     best_q;
    logic [EW-1:0]     min_err_q;
    logic              locked_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_q;

    logic              err_d;
    logic              win_last_d;
    logic [EW-1:0]     win_total_d;
    logic              better_d;
    logic [EW-1:0]     best_d;
    logic [PW-1:0]     best_pos_d;

    // Comparison uses the pre-shift history, so position p is a delay of p+1 samples.
    always_comb begin
        err_d       = i_data ^ hist_q[pos_q];
        win_last_d  = (win_cnt_q == WIN_LAST);
        win_total_d = win_err_q + EW'(err_d);
        better_d    = (win_total_d < best_q);
        best_d      = better_d ? win_total_d : best_q;
        best_pos_d  = better_d ? pos_q : best_pos_q;
    end

`ifdef BER_RELOCK_EN
    localparam logic [EW-1:0] LOSS_THR_C = EW'(LOSS_THR);
    logic [15:0] resync_q;
`endif

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q    <= ST_SEARCH;
            hist_q     <= '0;
            pos_q      <= '0;
            position_q <= '0;
            best_pos_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            best_q     <= '1;
            min_err_q  <= '1;
            locked_q   <= 1'b0;
            err_cnt_q  <= '0;
            bit_cnt_q  <= '0;
`ifdef BER_RELOCK_EN
            resync_q   <= '0;
`endif
        end else if (i_enable) begin
            if (i_valid) begin
                hist_q <= {hist_q[DEPTH-2:0], i_ref};
            end
            if (i_clear) begin
                err_cnt_q <= '0;
                bit_cnt_q <= '0;
            end
            case (state_q)
                ST_SEARCH: begin
                    if (i_valid) begin
                        if (win_last_d) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                            if (pos_q == POS_LAST) begin
                                min_err_q <= best_d;
                                if (best_d <= LOCK_THR_C) begin
                                    state_q    <= ST_LOCKED;
                                    locked_q   <= 1'b1;
                                    position_q <= best_pos_d;
                                    pos_q      <= best_pos_d;
                                    best_q     <= best_d;
                                    best_pos_q <= best_pos_d;
                                end else begin
                                    best_q     <= '1;
                                    best_pos_q <= '0;
                                    pos_q      <= '0;
                                end
                            end else begin
                                best_q     <= best_d;
                                best_pos_q <= best_pos_d;
                                pos_q      <= pos_q + PW'(1);
                            end
                        end else begin
                            win_cnt_q <= win_cnt_q + EW'(1);
                            win_err_q <= win_total_d;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (i_valid) begin
                        // A simultaneous clear discards this sample from the accumulators.
                        if (!i_clear) begin
                            if (bit_cnt_q != '1) begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                            if (err_d && (err_cnt_q != '1)) begin
                                err_cnt_q <= err_cnt_q + CNT_W'(1);
                            end
                        end
`ifdef BER_RELOCK_EN
                        if (win_last_d) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                            if (win_total_d > LOSS_THR_C) begin
                                state_q  <= ST_SEARCH;
                                locked_q <= 1'b0;
                                pos_q    <= '0;
                                best_q   <= '1;
                                best_pos_q <= '0;
                                if (resync_q != 16'hFFFF) begin
                                    resync_q <= resync_q + 16'd1;
                                end
                            end
                        end else begin
                            win_cnt_q <= win_cnt_q + EW'(1);
                            win_err_q <= win_total_d;
                        end
`endif
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

    assign o_locked    = locked_q;
    assign o_position  = position_q;
    assign o_min_err   = min_err_q;
    assign o_err_count = err_cnt_q;
    assign o_bit_count = bit_cnt_q;
`ifdef BER_RELOCK_EN
    assign o_resync_count = resync_q;
`else
    assign o_resync_count = 16'd0;
`endif

endmodule

// File: tb/tb_ber_checker_param.sv
// Self-checking bench for ber_checker_param: table vectors, directed sequences and a log-based reference model.
module tb_ber_checker_param;

    localparam int DEPTH    = 16;
    localparam int WIN      = 31;
    localparam int LOSS_THR = 4;
    localparam int PW       = 4;
    localparam int EW       = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic i_reset, i_enable, i_valid, i_data, i_ref, i_clear;
    logic          o_locked, s_locked;
    logic [PW-1:0] o_position, s_position;
    logic [EW-1:0] o_min_err, s_min_err;
    logic [63:0]   o_err_count, o_bit_count;
    logic [3:0]    s_err_count, s_bit_count;
    logic [15:0]   o_resync_count, s_resync_count;

    ber_checker_param #(.DEPTH(DEPTH), .WIN(WIN), .LOCK_THR(0), .LOSS_THR(LOSS_THR), .CNT_W(64)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_data(i_data), .i_ref(i_ref), .i_clear(i_clear),
        .o_locked(o_locked), .o_position(o_position), .o_min_err(o_min_err),
        .o_err_count(o_err_count), .o_bit_count(o_bit_count), .o_resync_count(o_resync_count)
    );

    // Narrow-counter instance, used to observe accumulator saturation.
    ber_checker_param #(.DEPTH(DEPTH), .WIN(WIN), .LOCK_THR(0), .LOSS_THR(LOSS_THR), .CNT_W(4)) dut_s (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_data(i_data), .i_ref(i_ref), .i_clear(i_clear),
        .o_locked(s_locked), .o_position(s_position), .o_min_err(s_min_err),
        .o_err_count(s_err_count), .o_bit_count(s_bit_count), .o_resync_count(s_resync_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: keeps the whole consumed sample log and evaluates windows from it.
    bit              ref_log[$];
    bit              data_log[$];
    bit              m_locked;
    int              m_pos, m_min_err, m_resync, sweep_start, mon_start;
    longint unsigned m_bits, m_errs;
    int              delay;

    function automatic bit hist_at(int n, int p);
        return (n - 1 - p >= 0) ? ref_log[n - 1 - p] : 1'b0;
    endfunction

    function automatic int win_errs(int first, int p);
        int e = 0;
        for (int k = first; k < first + WIN; k++) e += int'(data_log[k] ^ hist_at(k, p));
        return e;
    endfunction

    task automatic model_edge(input bit rst, input bit en, input bit v, input bit clr,
                              input bit d, input bit r);
        int n, best, bp, e;
        if (!rst) begin
            ref_log.delete(); data_log.delete();
            m_locked = 0; m_pos = 0; m_min_err = 31; m_resync = 0;
            m_bits = 0; m_errs = 0; sweep_start = 0; mon_start = 0;
            return;
        end
        if (!en) return;
        if (clr) begin m_bits = 0; m_errs = 0; end
        if (!v) return;
        n = data_log.size();
        data_log.push_back(d);
        ref_log.push_back(r);
        if (!m_locked) begin
            if (n - sweep_start == DEPTH * WIN - 1) begin
                best = 1 << 30; bp = 0;
                for (int p = 0; p < DEPTH; p++) begin
                    e = win_errs(sweep_start + p * WIN, p);
                    if (e < best) begin best = e; bp = p; end
                end
                m_min_err = best;
                if (best <= 0) begin
                    m_locked = 1; m_pos = bp; mon_start = n + 1;
                end else begin
                    sweep_start = n + 1;
                end
            end
        end else begin
            if (!clr) begin
                m_bits++;
                m_errs += longint'(d ^ hist_at(n, m_pos));
            end
`ifdef BER_RELOCK_EN
            if (((n - mon_start) % WIN == WIN - 1) && (win_errs(n - WIN + 1, m_pos) > LOSS_THR)) begin
                m_locked = 0; m_resync++; sweep_start = n + 1;
            end
`endif
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_locked"}, o_locked, m_locked);
        check({tag, "_min_err"}, o_min_err, m_min_err);
        check({tag, "_bits"}, o_bit_count, m_bits);
        check({tag, "_errs"}, o_err_count, m_errs);
`ifdef BER_RELOCK_EN
        check({tag, "_resync"}, o_resync_count, m_resync);
`else
        check({tag, "_resync"}, o_resync_count, 0);
`endif
        if (m_locked) check({tag, "_position"}, o_position, m_pos);
    endtask

    task automatic step(input bit en, input bit v, input bit clr, input bit flip);
        int n;
        bit r, d;
        n = data_log.size();
        r = 1'(($urandom() >> 7) & 1);
        d = ((n - delay >= 0) ? ref_log[n - delay] : 1'b0) ^ flip;
        i_reset = 1'b1; i_enable = en; i_valid = v; i_clear = clr; i_data = d; i_ref = r;
        @(posedge clock);
        model_edge(1'b1, en, v, clr, d, r);
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset();
        i_reset = 1'b0; i_enable = 1'b1; i_valid = 1'b1; i_clear = 1'b0;
        i_data = 1'b1; i_ref = 1'b1;
        @(posedge clock);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        compare_all("reset");
        i_reset = 1'b1;
    endtask

    typedef struct {
        bit en, v, clr, flip;
        int bits, errs;
    } vec_t;
    vec_t tbl[10];

    logic [EW-1:0] save_min;
    int            vc;

    initial begin
        tbl = '{
            '{1, 1, 1, 0, 0, 0},
            '{1, 1, 0, 0, 1, 0},
            '{1, 1, 0, 1, 2, 1},
            '{1, 0, 0, 1, 2, 1},
            '{0, 1, 0, 1, 2, 1},
            '{0, 1, 1, 0, 2, 1},
            '{1, 1, 0, 1, 3, 2},
            '{1, 1, 1, 1, 0, 0},
            '{1, 1, 0, 0, 1, 0},
            '{1, 0, 1, 0, 0, 0}
        };
        i_reset = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
        i_data = 1'b0; i_ref = 1'b0;
        delay = 5;
        repeat (2) @(posedge clock);

        // Reset state
        do_reset();
        check("rst_locked", o_locked, 0);
        check("rst_min_err", o_min_err, 5'h1F);
        check("rst_bits", o_bit_count, 0);

        // Error-free stream delayed by 5 locks at position 4 after 16*31 samples
        repeat (DEPTH * WIN - 1) step(1, 1, 0, 0);
        check("t1_not_yet", o_locked, 0);
        step(1, 1, 0, 0);
        check("t1_locked", o_locked, 1);
        check("t1_position", o_position, 4);
        check("t1_min_err", o_min_err, 0);

        // Table vectors: enable, valid and clear interactions while locked
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].v, tbl[i].clr, tbl[i].flip);
            check($sformatf("tbl%0d_bits", i), o_bit_count, 64'(tbl[i].bits));
            check($sformatf("tbl%0d_errs", i), o_err_count, 64'(tbl[i].errs));
        end

        // 1000 valid samples at 50% duty with 3 injected errors, then clear with a sample
        step(1, 1, 1, 0);
        vc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) begin
                step(1, 1, 0, (vc == 100) || (vc == 400) || (vc == 800));
                vc++;
            end else begin
                step(1, 0, 0, 1);
            end
        end
        check("t3_bits", o_bit_count, 1000);
        check("t3_errs", o_err_count, 3);
        check("t3_sat_bits", s_bit_count, 15);
        check("t3_sat_errs", s_err_count, 3);
        step(1, 1, 1, 1);
        check("t3_clr_bits", o_bit_count, 0);
        check("t3_clr_errs", o_err_count, 0);

`ifdef BER_RELOCK_EN
        // Delay change: lock drops at a window end, relock at position 8
        delay = 9;
        for (int i = 0; i < WIN + 2; i++) begin
            if (!o_locked) break;
            step(1, 1, 0, 0);
        end
        check("t5_unlock", o_locked, 0);
        check("t5_resync1", o_resync_count, 1);
        repeat (DEPTH * WIN - 1) step(1, 1, 0, 0);
        check("t5_not_yet", o_locked, 0);
        step(1, 1, 0, 0);
        check("t5_relock", o_locked, 1);
        check("t5_position", o_position, 8);
        for (int i = 0; i < WIN; i++) step(1, 1, 0, i < LOSS_THR);
        check("t5_thr_keep", o_locked, 1);
        check("t5_thr_resync", o_resync_count, 1);
        for (int i = 0; i < WIN; i++) step(1, 1, 0, i < LOSS_THR + 1);
        check("t5_over_thr", o_locked, 0);
        check("t5_resync2", o_resync_count, 2);
        repeat (DEPTH * WIN) step(1, 1, 0, 0);
        check("t5_relock2", o_locked, 1);
        check("t5_position2", o_position, 8);
`else
        // Without relock, lock is terminal even when the stream moves
        delay = 9;
        repeat (3 * WIN) step(1, 1, 0, 0);
        check("t5_terminal", o_locked, 1);
        check("t5_position", o_position, 4);
        check("t5_resync0", o_resync_count, 0);
`endif

        // Reset in the middle of lock
        repeat (20) step(1, 1, 0, 0);
        do_reset();
        check("t6_locked", o_locked, 0);
        check("t6_bits", o_bit_count, 0);
        check("t6_errs", o_err_count, 0);
        check("t6_min_err", o_min_err, 5'h1F);

        // Enable pause mid-sweep; the sweep resumes exactly where it stopped
        delay = 5;
        repeat (200) step(1, 1, 0, 0);
        save_min = o_min_err;
        for (int i = 0; i < 100; i++)
            step(0, 1'(($urandom() >> 3) & 1), 1'(($urandom() >> 5) & 1), 1'(($urandom() >> 9) & 1));
        check("t4_locked", o_locked, 0);
        check("t4_min_err", o_min_err, save_min);
        repeat (DEPTH * WIN - 201) step(1, 1, 0, 0);
        check("t4_not_yet", o_locked, 0);
        step(1, 1, 0, 0);
        check("t4_locked_after", o_locked, 1);
        check("t4_position", o_position, 4);

        // One error in every window: never locks, min error reported as 1 each sweep
        do_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH * WIN; i++) step(1, 1, 0, (i % WIN) == 0);
            check($sformatf("t2_locked_s%0d", s), o_locked, 0);
            check($sformatf("t2_min_err_s%0d", s), o_min_err, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
